// File: rtl/fwd_track_unit.sv
// ---------------------------------------------------------------------------
// fwd_track_unit
//
// Purpose
//   Forwarding and load-use detection for the EX stage. The unit keeps its own
//   tag pipeline: one tag for the instruction in EX plus DEPTH tags for the
//   downstream stages (index 0 = MEM, 1 = WB, ...). Each tag records
//   {valid, rd, we, is_load}.
//
//   For every EX source operand, the youngest downstream producer of that
//   register is selected. If that producer's data is available, its data is
//   forwarded. If it is a load whose data is not available yet, the unit
//   raises stall. During a stall it holds the EX tag and inserts a bubble
//   into tag[0] itself.
//
// Optional feature
//   FWD_PERF_EN : adds perf_stall_cnt. This saturating counter counts the
//                 cycles in which stall is high and hold is low.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   hold            external pipeline freeze, all tags keep their value
//   flush           kill the instruction entering EX this cycle
//   id_valid        ID stage holds a valid instruction
//   id_rd           ID destination register
//   id_we           ID instruction writes rd
//   id_is_load      ID instruction is a load
//   ex_rs           EX source indices, source k at [k*REGW +: REGW]
//   ex_rs_used      source k is actually read by the EX instruction
//   stage_data      write-back value of stage i at [i*XLEN +: XLEN]
//   fwd_hit         source k takes forwarded data
//   fwd_data        forwarded value per source, zero when there is no hit
//   stall           load-use stall: hold ID/EX, bubble into MEM
//   perf_stall_cnt  stall cycle counter (FWD_PERF_EN only)
// ---------------------------------------------------------------------------
module fwd_track_unit #(
   parameter int XLEN     = 32,
   parameter int REGW     = 5,
   parameter int DEPTH    = 2,
   parameter int NSRC     = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic                   flush,
   input  logic                   id_valid,
   input  logic [REGW-1:0]        id_rd,
   input  logic                   id_we,
   input  logic                   id_is_load,
   input  logic [NSRC*REGW-1:0]   ex_rs,
   input  logic [NSRC-1:0]        ex_rs_used,
   input  logic [DEPTH*XLEN-1:0]  stage_data,
   output logic [NSRC-1:0]        fwd_hit,
   output logic [NSRC*XLEN-1:0]   fwd_data,
   output logic                   stall
`ifdef FWD_PERF_EN
   ,
   output logic [31:0]            perf_stall_cnt
`endif
);

   typedef struct packed {
      logic            v;
      logic [REGW-1:0] rd;
      logic            we;
      logic            ld;
   } tag_t;

   localparam tag_t BUBBLE = '0;

   tag_t ex_tag;
   tag_t tag_q [DEPTH];

   // Producer selection per source operand. The stages are scanned from the
   // youngest (index 0) to the oldest, and only the first match counts. When
   // that youngest match is a load that has not reached LOAD_LAT yet, no
   // data is forwarded: an older match in a later stage holds a stale value,
   // so the unit stalls instead.
   always_comb begin : fwd_select
      logic found;
      fwd_hit  = '0;
      fwd_data = '0;
      stall    = 1'b0;
      found    = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         found = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (!found && ex_tag.v && ex_rs_used[k] &&
                (ex_rs[k*REGW +: REGW] != '0) &&
                tag_q[i].v && tag_q[i].we &&
                (tag_q[i].rd == ex_rs[k*REGW +: REGW])) begin
               found = 1'b1;
               if (!tag_q[i].ld || (i >= LOAD_LAT)) begin
                  fwd_hit[k]                 = 1'b1;
                  fwd_data[k*XLEN +: XLEN]   = stage_data[i*XLEN +: XLEN];
               end else begin
                  stall = 1'b1;
               end
            end
         end
      end
   end

   // Tag pipeline. When the unit stalls, the EX tag stays in place and a
   // bubble moves into tag[0]. The load therefore keeps advancing, and the
   // stall ends by itself. A flush always clears EX, even during hold, and
   // it wins over the stall. Invalid ID slots are stored as full bubbles, so
   // no stale rd bits remain in the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_tag <= BUBBLE;
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= BUBBLE;
      end else if (!hold) begin
         for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
         tag_q[0] <= stall ? BUBBLE : ex_tag;
         if (flush)
            ex_tag <= BUBBLE;
         else if (!stall)
            ex_tag <= id_valid ? {id_valid, id_rd, id_we, id_is_load} : BUBBLE;
      end else if (flush) begin
         ex_tag <= BUBBLE;
      end
   end

`ifdef FWD_PERF_EN
   // Stall cycle counter. It counts only the cycles in which the stall
   // actually holds the pipeline. It saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_stall_cnt <= '0;
      else if (stall && !hold && (perf_stall_cnt != 32'hFFFF_FFFF))
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fwd_track_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_track_unit
//
// Testbench for fwd_track_unit with the default parameters.
//
// Each table row gives the inputs for one clock cycle and the outputs that
// this cycle must produce. The rows are applied in consecutive cycles. The
// expected results go into a scoreboard queue when a row is driven. They are
// taken out and compared at the falling edge. A hand-written sequence then
// applies an asynchronous reset in the middle of a run.
//
// Build the bench with FWD_PERF_EN defined to also check the stall counter.
// ---------------------------------------------------------------------------
module tb_fwd_track_unit;

   localparam int XLEN  = 32;
   localparam int REGW  = 5;
   localparam int DEPTH = 2;
   localparam int NSRC  = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  hold;
   logic                  flush;
   logic                  id_valid;
   logic [REGW-1:0]       id_rd;
   logic                  id_we;
   logic                  id_is_load;
   logic [NSRC*REGW-1:0]  ex_rs;
   logic [NSRC-1:0]       ex_rs_used;
   logic [DEPTH*XLEN-1:0] stage_data;
   logic [NSRC-1:0]       fwd_hit;
   logic [NSRC*XLEN-1:0]  fwd_data;
   logic                  stall;
`ifdef FWD_PERF_EN
   logic [31:0]           perf_stall_cnt;
`endif

   fwd_track_unit #(
      .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_LAT(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hold(hold),
      .flush(flush),
      .id_valid(id_valid),
      .id_rd(id_rd),
      .id_we(id_we),
      .id_is_load(id_is_load),
      .ex_rs(ex_rs),
      .ex_rs_used(ex_rs_used),
      .stage_data(stage_data),
      .fwd_hit(fwd_hit),
      .fwd_data(fwd_data),
      .stall(stall)
`ifdef FWD_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   // 10 time-unit clock period. Rising edges fall at 5, 15, 25, ...
   always #5 clk = ~clk;

   typedef struct packed {
      logic        hold;
      logic        flush;
      logic        iv;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [4:0]  rs0;
      logic [4:0]  rs1;
      logic [1:0]  used;
      logic [31:0] sd0;
      logic [31:0] sd1;
      logic [1:0]  eHit;
      logic [31:0] eD0;
      logic [31:0] eD1;
      logic        eStall;
      logic [31:0] ePerf;
   } vec_t;

   typedef struct packed {
      logic [1:0]  hit;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        stl;
      logic [31:0] perf;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Append one cycle of stimulus and its expected outputs to the table.
   task automatic addVec(input logic h, input logic f, input logic iv,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] u,
                         input logic [31:0] s0, input logic [31:0] s1,
                         input logic [1:0] eh,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic es, input logic [31:0] ep);
      vec_t v;
      v.hold = h;   v.flush = f;  v.iv = iv;  v.rd = rd;  v.we = we; v.ld = ld;
      v.rs0 = r0;   v.rs1 = r1;   v.used = u; v.sd0 = s0; v.sd1 = s1;
      v.eHit = eh;  v.eD0 = e0;   v.eD1 = e1; v.eStall = es; v.ePerf = ep;
      vecs.push_back(v);
   endtask

   // Compare one value and record the result.
   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h",
                  name, idx, act, exp);
      end
   endtask

   // Drive one table row and put its expected outputs into the scoreboard.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      hold       = v.hold;
      flush      = v.flush;
      id_valid   = v.iv;
      id_rd      = v.rd;
      id_we      = v.we;
      id_is_load = v.ld;
      ex_rs      = {v.rs1, v.rs0};
      ex_rs_used = v.used;
      stage_data = {v.sd1, v.sd0};
      e.hit  = v.eHit;
      e.d0   = v.eD0;
      e.d1   = v.eD1;
      e.stl  = v.eStall;
      e.perf = v.ePerf;
      sb.push_back(e);
   endtask

   // Take the oldest expectation out of the scoreboard and compare it with
   // the DUT outputs.
   task automatic checkScoreboard(input int idx);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard (vec %0d): got empty queue, expected entry", idx);
      end else begin
         e = sb.pop_front();
         checkOutput("fwd_hit", idx, {30'b0, fwd_hit}, {30'b0, e.hit});
         checkOutput("fwd_data0", idx, fwd_data[31:0], e.d0);
         checkOutput("fwd_data1", idx, fwd_data[63:32], e.d1);
         checkOutput("stall", idx, {31'b0, stall}, {31'b0, e.stl});
`ifdef FWD_PERF_EN
         checkOutput("perf_stall_cnt", idx, perf_stall_cnt, e.perf);
`endif
      end
   endtask

   initial begin
      // Columns: hold flush | id v rd we ld | rs0 rs1 used | sd0 sd1 |
      //          exp hit d0 d1 stall perf
      // ALU chain: addi x5, then addi x5 that reads x5.
      addVec(0,0, 1, 5,1,0,  0, 0,2'b00, 'h00,'h00, 2'b00,'h00,'h00,0,0); // 0
      addVec(0,0, 1, 5,1,0,  0, 0,2'b00, 'h00,'h00, 2'b00,'h00,'h00,0,0); // 1
      addVec(0,0, 1, 8,1,0,  5, 0,2'b01, 'h11,'h22, 2'b01,'h11,'h00,0,0); // 2
      // Priority: x5 in tag0 and tag1, so tag0 wins. rs1 = x0 never hits.
      addVec(0,0, 1, 9,1,0,  5, 0,2'b11, 'hAA,'hBB, 2'b01,'hAA,'h00,0,0); // 3
      addVec(0,0, 0, 0,0,0,  5, 8,2'b11, 'h80,'h55, 2'b11,'h55,'h80,0,0); // 4
      // Invalid EX never hits. An unused source never hits.
      addVec(0,0, 1, 7,1,1,  9, 0,2'b01, 'h99,'h00, 2'b00,'h00,'h00,0,0); // 5
      addVec(0,0, 1,10,1,0,  9, 5,2'b00, 'h99,'h00, 2'b00,'h00,'h00,0,0); // 6
      // Load-use on x7: stall for one cycle, then forward from WB. tag0 is
      // a bubble, so rd10 (the stalled consumer) is not visible there.
      addVec(0,0, 1,11,1,0,  7,10,2'b11, 'h70,'h77, 2'b00,'h00,'h00,1,0); // 7
      addVec(0,0, 1,11,1,0,  7,10,2'b11, 'h70,'h77, 2'b01,'h77,'h00,0,1); // 8
      addVec(0,0, 0, 0,0,0, 10, 7,2'b11, 'h10,'h77, 2'b01,'h10,'h00,0,1); // 9
      // Load-use with a three-cycle hold: the stall stays high.
      addVec(0,0, 1,12,1,1,  0, 0,2'b00, 'h00,'h00, 2'b00,'h00,'h00,0,1); // 10
      addVec(0,0, 1,13,1,0, 11, 0,2'b01, 'h01,'hE1, 2'b01,'hE1,'h00,0,1); // 11
      addVec(1,0, 1,20,1,0, 12, 0,2'b01, 'hC0,'hC1, 2'b00,'h00,'h00,1,1); // 12
      addVec(1,0, 1,20,1,0, 12, 0,2'b01, 'hC0,'hC1, 2'b00,'h00,'h00,1,1); // 13
      addVec(1,0, 1,20,1,0, 12, 0,2'b01, 'hC0,'hC1, 2'b00,'h00,'h00,1,1); // 14
      addVec(0,0, 1,20,1,0, 12, 0,2'b01, 'hC0,'hC1, 2'b00,'h00,'h00,1,1); // 15
      addVec(0,0, 1,20,1,0, 12, 0,2'b01, 'hC0,'hC1, 2'b01,'hC1,'h00,0,2); // 16
      // A load that reads two non-load producers, then a flush during the
      // stall.
      addVec(0,0, 1,14,1,1, 13, 0,2'b01, 'hD0,'h00, 2'b01,'hD0,'h00,0,2); // 17
      addVec(0,0, 1,15,1,0, 20,13,2'b11, 'h20,'h13, 2'b11,'h20,'h13,0,2); // 18
      addVec(0,1, 1,16,1,0, 14, 0,2'b01, 'h14,'h41, 2'b00,'h00,'h00,1,2); // 19
      addVec(0,0, 1,16,1,0, 14, 0,2'b01, 'h14,'h41, 2'b00,'h00,'h00,0,3); // 20
      addVec(0,0, 0, 0,0,0, 14,16,2'b11, 'h14,'h41, 2'b00,'h00,'h00,0,3); // 21
      // Two valid producers in flight before the reset.
      addVec(0,0, 1,17,1,0,  0, 0,2'b00, 'h00,'h00, 2'b00,'h00,'h00,0,3); // 22
      addVec(0,0, 1,18,1,0, 16, 0,2'b01, 'h00,'h16, 2'b01,'h16,'h00,0,3); // 23
      addVec(0,0, 1,19,1,0, 17, 0,2'b01, 'h17,'h00, 2'b01,'h17,'h00,0,3); // 24
      addVec(0,0, 0, 0,0,0, 17,18,2'b11, 'h18,'h17, 2'b11,'h17,'h18,0,3); // 25

      // Reset state
      rst_n = 1'b0;
      hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rd = '0; id_we = 1'b0;
      id_is_load = 1'b0; ex_rs = '0; ex_rs_used = '0; stage_data = '0;
      #12;
      checkOutput("reset_fwd_hit", -1, {30'b0, fwd_hit}, 32'd0);
      checkOutput("reset_fwd_data0", -1, fwd_data[31:0], 32'd0);
      checkOutput("reset_stall", -1, {31'b0, stall}, 32'd0);
`ifdef FWD_PERF_EN
      checkOutput("reset_perf", -1, perf_stall_cnt, 32'd0);
`endif
      rst_n = 1'b1;

      // Table-driven part: one row per clock cycle
      $display("[TB] applying %0d vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkScoreboard(i);
      end

      // Asynchronous reset in the middle of a run, with two valid producers
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_fwd_hit", 100, {30'b0, fwd_hit}, 32'd0);
      checkOutput("midreset_fwd_data0", 100, fwd_data[31:0], 32'd0);
      checkOutput("midreset_fwd_data1", 100, fwd_data[63:32], 32'd0);
      checkOutput("midreset_stall", 100, {31'b0, stall}, 32'd0);
`ifdef FWD_PERF_EN
      checkOutput("midreset_perf", 100, perf_stall_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      id_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postreset_fwd_hit", 101, {30'b0, fwd_hit}, 32'd0);
      checkOutput("postreset_stall", 101, {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("postreset2_fwd_hit", 102, {30'b0, fwd_hit}, 32'd0);
      checkOutput("postreset2_fwd_data0", 102, fwd_data[31:0], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
